fifo_rd_streamer: RTL and testbench



---
 rtl/fifo_rd_streamer_pkg.sv | 6 +
 rtl/fifo_rd_streamer_skid.sv | 41 ++++
 rtl/fifo_rd_streamer.sv | 81 ++++++++
 tb/tb_fifo_rd_streamer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_streamer_pkg.sv
// FIFO_pkg: shared FIFO word width, read-streamer depth and word type
package FIFO_pkg;
  localparam int FIFO_WIDTH = 16;
  localparam int RD_STREAMER_DEPTH = 2;
  typedef logic [FIFO_WIDTH-1:0] rd_word_t;
endpackage

// File: rtl/fifo_rd_streamer_skid.sv
// rd_skid_buf: 2-entry register buffer; push/pop/flush in, occupancy and head word out
// Ports: clk, rst (sync flush), push + push_data (write at tail), pop (retire head),
//        count (0..2), head_data (registered head entry, zero after flush)
module rd_skid_buf import FIFO_pkg::*; #(
  parameter int W = FIFO_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [1:0]   count,
  output logic [W-1:0] head_data
);
  logic [W-1:0] mem_q [RD_STREAMER_DEPTH];
  logic [W-1:0] mem_d [RD_STREAMER_DEPTH];
  logic head_q, head_d, tail_q, tail_d;
  logic [1:0] count_q, count_d;
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[tail_q] = push_data;
    head_d = pop ? ~head_q : head_q;
    tail_d = push ? ~tail_q : tail_q;
    count_d = count_q + {1'b0, push} - {1'b0, pop};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '{default: '0};
      head_q <= 1'b0;
      tail_q <= 1'b0;
      count_q <= 2'd0;
    end else begin
      mem_q <= mem_d;
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
    end
  end
  assign count = count_q;
  assign head_data = mem_q[head_q];
endmodule

// File: rtl/fifo_rd_streamer.sv
// fifo_rd_streamer: turns FIFO rd_en/data_out (1-cycle latency) into a bubble-free valid/ready stream
// Ports: clk, rst (sync, active high), enable, fifo_empty, fifo_underflow, fifo_data_out in;
//        fifo_rd_en, m_data, m_valid out; m_ready in; rd_count, err_underflow out.
// Macro FIFO_RD_STREAMER_PERF_EN adds saturating stall_cycles / starve_cycles outputs.
module fifo_rd_streamer #(
  parameter int FIFO_WIDTH = FIFO_pkg::FIFO_WIDTH,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic                  fifo_underflow,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  output logic                  fifo_rd_en,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  rd_count,
`ifdef FIFO_RD_STREAMER_PERF_EN
  output logic [CNT_WIDTH-1:0]  stall_cycles,
  output logic [CNT_WIDTH-1:0]  starve_cycles,
`endif
  output logic                  err_underflow
);
  logic inflight_q, inflight_d, pop, err_q, err_d;
  logic [1:0] buf_count;
  logic [2:0] occ;
  logic [CNT_WIDTH-1:0] rd_count_q, rd_count_d;
  rd_skid_buf #(.W(FIFO_WIDTH)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_q),
    .pop       (pop),
    .push_data (fifo_data_out),
    .count     (buf_count),
    .head_data (m_data)
  );
  // occ is the occupancy left after this cycle's pop; reading only when it is <= 1
  // keeps buffered + in-flight words within the two buffer slots.
  always_comb begin
    m_valid = buf_count != 2'd0;
    pop = m_valid & m_ready;
    occ = {1'b0, buf_count} + {2'b0, inflight_q} - {2'b0, pop};
    fifo_rd_en = ~rst & enable & ~fifo_empty & (occ <= 3'd1);
    inflight_d = fifo_rd_en;
    rd_count_d = rd_count_q + {{(CNT_WIDTH-1){1'b0}}, pop};
    err_d = err_q | fifo_underflow;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q <= 1'b0;
      rd_count_q <= '0;
      err_q <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      rd_count_q <= rd_count_d;
      err_q <= err_d;
    end
  end
  assign rd_count = rd_count_q;
  assign err_underflow = err_q;
`ifdef FIFO_RD_STREAMER_PERF_EN
  logic [CNT_WIDTH-1:0] stall_q, stall_d, starve_q, starve_d;
  always_comb begin
    stall_d = stall_q + {{(CNT_WIDTH-1){1'b0}}, m_valid & ~m_ready & ~&stall_q};
    starve_d = starve_q + {{(CNT_WIDTH-1){1'b0}}, enable & fifo_empty & ~m_valid & ~&starve_q};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      starve_q <= '0;
    end else begin
      stall_q <= stall_d;
      starve_q <= starve_d;
    end
  end
  assign stall_cycles = stall_q;
  assign starve_cycles = starve_q;
`endif
endmodule

// File: tb/tb_fifo_rd_streamer.sv
// tb_fifo_rd_streamer: FIFO model + in-order scoreboard checking of fifo_rd_streamer
module tb_fifo_rd_streamer;
  localparam int W = 16;
  logic clk = 1'b0, rst = 1'b1, enable = 1'b0, fifo_empty = 1'b1, fifo_underflow = 1'b0, m_ready = 1'b0;
  logic [W-1:0] fifo_data_out = '0, m_data;
  logic fifo_rd_en, m_valid, err_underflow;
  logic [15:0] rd_count;
`ifdef FIFO_RD_STREAMER_PERF_EN
  logic [15:0] stall_cycles, starve_cycles;
  int stall_exp = 0, starve_exp = 0;
`endif
  always #5 clk = ~clk;
  fifo_rd_streamer dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .fifo_empty     (fifo_empty),
    .fifo_underflow (fifo_underflow),
    .fifo_data_out  (fifo_data_out),
    .fifo_rd_en     (fifo_rd_en),
    .m_data         (m_data),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .rd_count       (rd_count),
`ifdef FIFO_RD_STREAMER_PERF_EN
    .stall_cycles   (stall_cycles),
    .starve_cycles  (starve_cycles),
`endif
    .err_underflow  (err_underflow)
  );
  int nvec = 0, nerr = 0, issued = 0, delivered = 0;
  logic [W-1:0] fifo_q [$];
  logic [W-1:0] sb [$];
  logic hold_v = 1'b0, err_exp = 1'b0, last_rd = 1'b0, last_v = 1'b0;
  logic [W-1:0] hold_d = '0, last_d = '0;
  typedef struct {
    int n;
    bit en;
    int hold;
    int exp_issued;
    bit exp_valid;
  } vec_t;
  vec_t tbl [5];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  task automatic load_word(input logic [W-1:0] w);
    fifo_q.push_back(w);
    fifo_empty = 1'b0;
  endtask
  // One clock: sample/check at negedge, update the FIFO model just after posedge.
  task automatic tick();
    logic rd, r, u, si, ti;
    logic [W-1:0] w;
    w = '0;
    @(negedge clk);
    rd = fifo_rd_en; r = rst; u = fifo_underflow;
    si = m_valid & ~m_ready;
    ti = enable & fifo_empty & ~m_valid;
    last_rd = rd; last_v = m_valid; last_d = m_data;
    if (!r) begin
      chk("rd_vs_empty", rd & fifo_empty, 0);
      if (hold_v) begin
        chk("hold_valid", m_valid, 1);
        chk("hold_data", m_data, hold_d);
      end
      if (m_valid && m_ready) begin
        chk("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) chk("stream_data", m_data, sb.pop_front());
        delivered++;
      end
      if (rd && fifo_q.size() != 0) begin
        w = fifo_q.pop_front();
        sb.push_back(w);
        issued++;
      end
      chk("outstanding_le2", (issued - delivered) <= 2, 1);
      hold_v = m_valid & ~m_ready;
      hold_d = m_data;
    end else begin
      chk("rd_en_in_rst", rd, 0);
      hold_v = 1'b0;
    end
    @(posedge clk); #1;
    if (r) begin
      fifo_q.delete(); sb.delete();
      issued = 0; delivered = 0; err_exp = 1'b0;
    end else if (u) err_exp = 1'b1;
    fifo_data_out = rd ? w : W'($urandom);
    fifo_empty = fifo_q.size() == 0;
    chk("rd_count", rd_count, delivered & 32'hFFFF);
    chk("err_underflow", err_underflow, err_exp);
`ifdef FIFO_RD_STREAMER_PERF_EN
    if (r) begin stall_exp = 0; starve_exp = 0; end
    else begin
      if (si && stall_exp < 65535) stall_exp++;
      if (ti && starve_exp < 65535) starve_exp++;
    end
    chk("stall_cycles", stall_cycles, stall_exp);
    chk("starve_cycles", starve_cycles, starve_exp);
`endif
  endtask
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask
  task automatic do_reset();
    rst = 1'b1;
    ticks(2);
    rst = 1'b0;
  endtask
  initial begin
    logic [7:0] rb, vb;
    logic [W-1:0] dq [$];
    int cnt;
    tbl[0] = '{n: 1, en: 1'b1, hold: 5, exp_issued: 1, exp_valid: 1'b1};
    tbl[1] = '{n: 2, en: 1'b1, hold: 5, exp_issued: 2, exp_valid: 1'b1};
    tbl[2] = '{n: 5, en: 1'b1, hold: 5, exp_issued: 2, exp_valid: 1'b1};
    tbl[3] = '{n: 3, en: 1'b0, hold: 5, exp_issued: 0, exp_valid: 1'b0};
    tbl[4] = '{n: 0, en: 1'b1, hold: 4, exp_issued: 0, exp_valid: 1'b0};
    enable = 1'b1; m_ready = 1'b1;
    load_word(16'h5555);
    #1 chk("rd_en_forced_low", fifo_rd_en, 0);
    ticks(2);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_rd_count", rd_count, 0);
    chk("rst_err", err_underflow, 0);
    rst = 1'b0;
    for (int i = 1; i <= 4; i++) load_word(W'(i));
    rb = '0; vb = '0;
    for (int c = 0; c < 8; c++) begin
      tick();
      rb[c] = last_rd; vb[c] = last_v;
      if (last_v) dq.push_back(last_d);
    end
    chk("drain_rd_pattern", rb, 8'h0F);
    chk("drain_valid_pattern", vb, 8'h3C);
    chk("drain_words", dq.size(), 4);
    for (int i = 0; i < dq.size(); i++) chk("drain_word", dq[i], i + 1);
    chk("drain_rd_count", rd_count, 4);
    do_reset();
    enable = 1'b1; m_ready = 1'b0;
    load_word(16'h1111); load_word(16'h2222); load_word(16'h3333);
    ticks(6);
    chk("bp_issued", issued, 2);
    chk("bp_valid", m_valid, 1);
    chk("bp_head", m_data, 16'h1111);
    m_ready = 1'b1;
    ticks(6);
    chk("bp_delivered", delivered, 3);
    chk("bp_rd_count", rd_count, 3);
    do_reset();
    load_word(16'hABCD);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin tick(); cnt += int'(last_rd); end
    chk("single_rd_pulses", cnt, 1);
    chk("single_delivered", delivered, 1);
    chk("single_err", err_underflow, 0);
    do_reset();
    load_word(16'h0101); load_word(16'h0202); load_word(16'h0303);
    tick();
    chk("endrop_first_rd", last_rd, 1);
    enable = 1'b0;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin tick(); cnt += int'(last_rd); end
    chk("endrop_no_rd", cnt, 0);
    chk("endrop_inflight_delivered", delivered, 1);
    enable = 1'b1;
    ticks(6);
    chk("endrop_resume", delivered, 3);
    do_reset();
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) load_word(W'(16'h0C00 + i));
    ticks(2);
    rst = 1'b1;
    tick();
    rst = 1'b0; m_ready = 1'b1;
    chk("midrst_valid", m_valid, 0);
    chk("midrst_rd_count", rd_count, 0);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin tick(); cnt += int'(last_v); end
    chk("midrst_no_stale", cnt, 0);
    do_reset();
    fifo_underflow = 1'b1;
    tick();
    fifo_underflow = 1'b0;
    chk("uf_set", err_underflow, 1);
    tick();
    chk("uf_sticky", err_underflow, 1);
    do_reset();
    chk("uf_cleared", err_underflow, 0);
    for (int t = 0; t < 5; t++) begin
      do_reset();
      enable = tbl[t].en; m_ready = 1'b0;
      for (int i = 0; i < tbl[t].n; i++) load_word(W'($urandom));
      ticks(tbl[t].hold);
      chk("tbl_issued", issued, tbl[t].exp_issued);
      chk("tbl_valid", m_valid, tbl[t].exp_valid);
      enable = 1'b1; m_ready = 1'b1;
      ticks(12);
      chk("tbl_delivered", delivered, tbl[t].n);
      chk("tbl_rd_count", rd_count, tbl[t].n);
    end
`ifdef FIFO_RD_STREAMER_PERF_EN
    begin
      logic [15:0] s0;
      do_reset();
      m_ready = 1'b0;
      load_word(16'h7777);
      ticks(2);
      s0 = stall_cycles;
      ticks(5);
      chk("perf_stall5", stall_cycles - s0, 5);
      m_ready = 1'b1;
      ticks(2);
      s0 = starve_cycles;
      ticks(3);
      chk("perf_starve3", starve_cycles - s0, 3);
    end
`endif
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom % 100) == 0;
      enable = ($urandom % 4) != 0;
      m_ready = ($urandom % 3) != 0;
      if (($urandom % 3) != 0 && fifo_q.size() < 8) load_word(W'($urandom));
      tick();
    end
    rst = 1'b0; enable = 1'b1; m_ready = 1'b1;
    ticks(30);
    chk("rand_fifo_drained", fifo_q.size(), 0);
    chk("rand_sb_drained", sb.size(), 0);
    chk("rand_all_delivered", delivered, issued);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
